// File: rtl/adder_arbiter_pkg.sv
// Shared constants, operand-stage record and lane helper for the shared SIMD adder
// and the arbiter that feeds it.
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        VEC_8  = 2'd0,
        VEC_16 = 2'd1,
        VEC_32 = 2'd2,
        VEC_64 = 2'd3
    } vec_e;

    localparam logic FORM_SPLIT = 1'b0;
    localparam logic FORM_SUM3  = 1'b1;

    typedef struct packed {
        logic        form;
        vec_e        vec;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic        src;
    } op_t;

    // Lane-wise x+y with each lane's carry-out dropped; VEC_64 is handled by the caller.
    function automatic logic [31:0] lane_add(input logic [31:0] x, input logic [31:0] y,
                                             input logic [1:0] vec);
        logic [31:0] r;
        r = '0;
        case (vec)
            VEC_8:   for (int i = 0; i < 4; i++) r[i*8 +: 8] = x[i*8 +: 8] + y[i*8 +: 8];
            VEC_16:  for (int i = 0; i < 2; i++) r[i*16 +: 16] = x[i*16 +: 16] + y[i*16 +: 16];
            default: r = x + y;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// SIMD adder: form 0 gives Y1=A+C, Y2=B+D per lane; form 1 gives {Y1,Y2}=A+B+C per lane
// (low lane bits in Y2, lane carry in Y1). vec=3 is a 64-bit {A,B}+{C,D} for either form.
module adder
    import adder_arbiter_pkg::*;
(
    input  logic        form_i,
    input  logic [1:0]  vec_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    output logic [31:0] y1_o,
    output logic [31:0] y2_o
);

    logic [9:0]  s8;
    logic [17:0] s16;
    logic [33:0] s32;

    always_comb begin
        y1_o = '0;
        y2_o = '0;
        s8   = '0;
        s16  = '0;
        s32  = '0;
        if (vec_i == VEC_64) begin
            {y1_o, y2_o} = {a_i, b_i} + {c_i, d_i};
        end else if (form_i == FORM_SPLIT) begin
            y1_o = lane_add(a_i, c_i, vec_i);
            y2_o = lane_add(b_i, d_i, vec_i);
        end else begin
            case (vec_i)
                VEC_8: for (int i = 0; i < 4; i++) begin
                    s8 = 10'(a_i[i*8 +: 8]) + 10'(b_i[i*8 +: 8]) + 10'(c_i[i*8 +: 8]);
                    y2_o[i*8 +: 8] = s8[7:0];
                    y1_o[i*8 +: 8] = {6'b0, s8[9:8]};
                end
                VEC_16: for (int i = 0; i < 2; i++) begin
                    s16 = 18'(a_i[i*16 +: 16]) + 18'(b_i[i*16 +: 16]) + 18'(c_i[i*16 +: 16]);
                    y2_o[i*16 +: 16] = s16[15:0];
                    y1_o[i*16 +: 16] = {14'b0, s16[17:16]};
                end
                default: begin
                    s32  = 34'(a_i) + 34'(b_i) + 34'(c_i);
                    y2_o = s32[31:0];
                    y1_o = {30'b0, s32[33:32]};
                end
            endcase
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Two-port front end for one shared SIMD adder: grant, S1 operand register,
// combinational adder, S2 result register with valid/ready backpressure.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter bit FAIR  = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_form,
    input  logic [1:0]       p0_vec,
    input  logic [31:0]      p0_a,
    input  logic [31:0]      p0_b,
    input  logic [31:0]      p0_c,
    input  logic [31:0]      p0_d,
    input  logic [TAG_W-1:0] p0_tag,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_form,
    input  logic [1:0]       p1_vec,
    input  logic [31:0]      p1_a,
    input  logic [31:0]      p1_b,
    input  logic [31:0]      p1_c,
    input  logic [31:0]      p1_d,
    input  logic [TAG_W-1:0] p1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_y1,
    output logic [31:0]      res_y2,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             busy
);

    logic             s1_valid_q, s1_valid_d;
    logic             s2_valid_q, s2_valid_d;
    logic             rr_last_q, rr_last_d;
    op_t              s1_op_q, s1_op_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
    logic [31:0]      res_y1_q, res_y1_d;
    logic [31:0]      res_y2_q, res_y2_d;
    logic             res_src_q, res_src_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    logic        s1_adv, s2_adv, grant_p1, accept;
    logic [31:0] sum_y1, sum_y2;

    assign s2_adv   = !s2_valid_q || res_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    // rr_last_q names the port served last, so under contention the other one wins.
    assign grant_p1 = p1_valid && (!p0_valid || (FAIR && !rr_last_q));
    assign p0_ready = !grant_p1 && s1_adv && resetn;
    assign p1_ready = grant_p1 && s1_adv && resetn;
    assign accept   = (p0_valid && p0_ready) || (p1_valid && p1_ready);

    adder u_adder (
        .form_i (s1_op_q.form),
        .vec_i  (s1_op_q.vec),
        .a_i    (s1_op_q.a),
        .b_i    (s1_op_q.b),
        .c_i    (s1_op_q.c),
        .d_i    (s1_op_q.d),
        .y1_o   (sum_y1),
        .y2_o   (sum_y2)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        rr_last_d  = rr_last_q;
        s1_op_d    = s1_op_q;
        s1_tag_d   = s1_tag_q;
        res_y1_d   = res_y1_q;
        res_y2_d   = res_y2_q;
        res_src_d  = res_src_q;
        res_tag_d  = res_tag_q;

        if (s1_adv) s1_valid_d = accept;
        if (accept) begin
            rr_last_d = grant_p1;
            if (grant_p1) begin
                s1_op_d  = '{form: p1_form, vec: vec_e'(p1_vec), a: p1_a, b: p1_b,
                             c: p1_c, d: p1_d, src: 1'b1};
                s1_tag_d = p1_tag;
            end else begin
                s1_op_d  = '{form: p0_form, vec: vec_e'(p0_vec), a: p0_a, b: p0_b,
                             c: p0_c, d: p0_d, src: 1'b0};
                s1_tag_d = p0_tag;
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_y1_d  = sum_y1;
                res_y2_d  = sum_y2;
                res_src_d = s1_op_q.src;
                res_tag_d = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            rr_last_q  <= 1'b1;
            res_y1_q   <= '0;
            res_y2_q   <= '0;
            res_src_q  <= 1'b0;
            res_tag_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            rr_last_q  <= rr_last_d;
            res_y1_q   <= res_y1_d;
            res_y2_q   <= res_y2_d;
            res_src_q  <= res_src_d;
            res_tag_q  <= res_tag_d;
        end
    end

    // NOTE: operand registers carry no reset; s1_valid_q alone qualifies their contents.
    always_ff @(posedge clk) begin
        s1_op_q  <= s1_op_d;
        s1_tag_q <= s1_tag_d;
    end

    assign res_valid = s2_valid_q;
    assign res_y1    = res_y1_q;
    assign res_y2    = res_y2_q;
    assign res_src   = res_src_q;
    assign res_tag   = res_tag_q;
    assign busy      = s1_valid_q || s2_valid_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus randomized traffic checked against
// a lane-arithmetic reference model and an in-order result scoreboard.
module tb_adder_arbiter;

    typedef struct packed {
        logic        valid;
        logic        form;
        logic [1:0]  vec;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [3:0]  tag;
    } req_t;

    typedef struct {
        logic [31:0] y1;
        logic [31:0] y2;
        logic        src;
        logic [3:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic resetn, res_ready, fres_ready;
    req_t r0, r1, f0, f1;

    logic        p0_ready, p1_ready, res_valid, res_src, busy;
    logic [31:0] res_y1, res_y2;
    logic [3:0]  res_tag;
    logic        fp_p0_ready, fp_p1_ready, fp_res_valid, fp_res_src, fp_busy;
    logic [31:0] fp_res_y1, fp_res_y2;
    logic [3:0]  fp_res_tag;

    int   checks, errors;
    exp_t exp_q[$];
    exp_t e;
    logic last_port;

    always #5 clk = ~clk;

    adder_arbiter #(.TAG_W(4), .FAIR(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(r0.valid), .p0_ready(p0_ready), .p0_form(r0.form), .p0_vec(r0.vec),
        .p0_a(r0.a), .p0_b(r0.b), .p0_c(r0.c), .p0_d(r0.d), .p0_tag(r0.tag),
        .p1_valid(r1.valid), .p1_ready(p1_ready), .p1_form(r1.form), .p1_vec(r1.vec),
        .p1_a(r1.a), .p1_b(r1.b), .p1_c(r1.c), .p1_d(r1.d), .p1_tag(r1.tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_y1(res_y1), .res_y2(res_y2),
        .res_src(res_src), .res_tag(res_tag), .busy(busy)
    );

    adder_arbiter #(.TAG_W(4), .FAIR(1'b0)) dut_fp (
        .clk(clk), .resetn(resetn),
        .p0_valid(f0.valid), .p0_ready(fp_p0_ready), .p0_form(f0.form), .p0_vec(f0.vec),
        .p0_a(f0.a), .p0_b(f0.b), .p0_c(f0.c), .p0_d(f0.d), .p0_tag(f0.tag),
        .p1_valid(f1.valid), .p1_ready(fp_p1_ready), .p1_form(f1.form), .p1_vec(f1.vec),
        .p1_a(f1.a), .p1_b(f1.b), .p1_c(f1.c), .p1_d(f1.d), .p1_tag(f1.tag),
        .res_valid(fp_res_valid), .res_ready(fres_ready), .res_y1(fp_res_y1),
        .res_y2(fp_res_y2), .res_src(fp_res_src), .res_tag(fp_res_tag), .busy(fp_busy)
    );

    // Reference arithmetic: slice each operand into lanes of 8<<vec bits with shifts and masks.
    function automatic logic [63:0] ref_add(input logic form, input logic [1:0] vec,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c, input logic [31:0] d);
        longint unsigned m, la, lb, lc, ld, s, y1, y2;
        int w, sh;
        if (vec == 2'd3) return {a, b} + {c, d};
        w  = 8 << vec;
        m  = (64'd1 << w) - 64'd1;
        y1 = 0;
        y2 = 0;
        for (int i = 0; i < 32 / w; i++) begin
            sh = i * w;
            la = (64'(a) >> sh) & m;
            lb = (64'(b) >> sh) & m;
            lc = (64'(c) >> sh) & m;
            ld = (64'(d) >> sh) & m;
            if (form == 1'b0) begin
                y1 = y1 | (((la + lc) & m) << sh);
                y2 = y2 | (((lb + ld) & m) << sh);
            end else begin
                s  = la + lb + lc;
                y2 = y2 | ((s & m) << sh);
                y1 = y1 | ((s >> w) << sh);
            end
        end
        return {y1[31:0], y2[31:0]};
    endfunction

    function automatic exp_t model_of(input req_t r, input logic src);
        logic [63:0] y;
        exp_t x;
        y     = ref_add(r.form, r.vec, r.a, r.b, r.c, r.d);
        x.y1  = y[63:32];
        x.y2  = y[31:0];
        x.src = src;
        x.tag = r.tag;
        return x;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.valid = 1'b1;
        r.form  = 1'($urandom);
        r.vec   = 2'($urandom);
        r.a     = $urandom;
        r.b     = $urandom;
        r.c     = $urandom;
        r.d     = $urandom;
        r.tag   = 4'($urandom);
        return r;
    endfunction

    // Scoreboard and arbitration model for the round-robin instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            last_port = 1'b1;
        end else begin
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_unexpected: got y1=%h y2=%h src=%0d tag=%h, none outstanding",
                             res_y1, res_y2, res_src, res_tag);
                end else begin
                    e = exp_q.pop_front();
                    if ({res_y1, res_y2, res_src, res_tag} !== {e.y1, e.y2, e.src, e.tag}) begin
                        errors++;
                        $display("FAIL result_data: got y1=%h y2=%h src=%0d tag=%h, want y1=%h y2=%h src=%0d tag=%h",
                                 res_y1, res_y2, res_src, res_tag, e.y1, e.y2, e.src, e.tag);
                    end
                end
            end
            if (r0.valid && r1.valid && (p0_ready || p1_ready)) begin
                checks++;
                if ((p0_ready && p1_ready) || (p1_ready !== (last_port == 1'b0))) begin
                    errors++;
                    $display("FAIL rr_grant: got p0_ready=%0d p1_ready=%0d, want p1 grant=%0d",
                             p0_ready, p1_ready, (last_port == 1'b0));
                end
            end
            if (r0.valid && p0_ready) begin
                exp_q.push_back(model_of(r0, 1'b0));
                last_port = 1'b0;
            end
            if (r1.valid && p1_ready) begin
                exp_q.push_back(model_of(r1, 1'b1));
                last_port = 1'b1;
            end
        end
    end

    task automatic drain();
        logic a0, a1;
        res_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            a0 = r0.valid && p0_ready;
            a1 = r1.valid && p1_ready;
            if (!r0.valid && !r1.valid && exp_q.size() == 0 && !busy) break;
            @(posedge clk); #1;
            if (a0) r0.valid = 1'b0;
            if (a1) r1.valid = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || r0.valid || r1.valid) begin
            errors++;
            $display("FAIL drain: got outstanding=%0d busy=%0d, want 0 and 0", exp_q.size(), busy);
        end
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        resetn   = 1'b0;
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        r0       = rand_req();
        r1       = rand_req();
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({res_valid, busy, res_src} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%0d busy=%0d src=%0d, want 0 0 0", res_valid, busy, res_src);
        end
        checks++;
        if ({res_y1, res_y2, res_tag} !== 68'd0) begin
            errors++;
            $display("FAIL reset_data: got y1=%h y2=%h tag=%h, want zeros", res_y1, res_y2, res_tag);
        end
        checks++;
        if ({p0_ready, p1_ready, fp_p0_ready, fp_p1_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b, want 0000", {p0_ready, p1_ready, fp_p0_ready, fp_p1_ready});
        end
        @(posedge clk); #1;
        r0.valid = 1'b0;
        r1.valid = 1'b0;
        resetn   = 1'b1;
    endtask

    task automatic run_directed(input string name, input logic form, input logic [1:0] vec,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d, input logic [3:0] tag,
                                input logic [31:0] want_y1, input logic [31:0] want_y2);
        int n;
        @(posedge clk); #1;
        r0        = '{valid: 1'b1, form: form, vec: vec, a: a, b: b, c: c, d: d, tag: tag};
        res_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!p0_ready && n < 20);
        checks++;
        if (p0_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept: got p0_ready=%0d, want 1 within 20 cycles", name, p0_ready);
        end
        @(posedge clk); #1;
        r0.valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!res_valid && n < 20);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, want 2", name, n);
        end
        checks++;
        if ({res_y1, res_y2, res_src, res_tag} !== {want_y1, want_y2, 1'b0, tag}) begin
            errors++;
            $display("FAIL %s_result: got y1=%h y2=%h src=%0d tag=%h, want y1=%h y2=%h src=0 tag=%h",
                     name, res_y1, res_y2, res_src, res_tag, want_y1, want_y2, tag);
        end
        drain();
    endtask

    task automatic test_single();
        run_directed("single", 1'b0, 2'd0, 32'h01020304, 32'h00000000, 32'hFF010101,
                     32'h00000000, 4'h5, 32'h00030405, 32'h00000000);
    endtask

    task automatic test_wide();
        run_directed("vec64", 1'b0, 2'd3, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h1, 4'h3,
                     32'h00000001, 32'h00000000);
        run_directed("sum3", 1'b1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'h9,
                     32'h00000002, 32'hFFFFFFFD);
    endtask

    task automatic test_contention();
        apply_reset();
        @(posedge clk); #1;
        r0 = rand_req();
        r1 = rand_req();
        res_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k < 5) begin
                checks++;
                if (p0_ready !== (k % 2 == 0) || p1_ready !== (k % 2 == 1)) begin
                    errors++;
                    $display("FAIL contention_grant%0d: got p0_ready=%0d p1_ready=%0d, want p0 grant=%0d",
                             k, p0_ready, p1_ready, (k % 2 == 0));
                end
            end
            if (k >= 2) begin
                checks++;
                if (res_valid !== 1'b1 || res_src !== 1'((k - 2) % 2)) begin
                    errors++;
                    $display("FAIL contention_result%0d: got valid=%0d src=%0d, want 1 %0d",
                             k, res_valid, res_src, (k - 2) % 2);
                end
            end
            @(posedge clk); #1;
            if (k % 2 == 0 && k < 4) r0 = rand_req();
            if (k == 4) r0.valid = 1'b0;
            if (k == 1) r1 = rand_req();
            if (k == 3) r1.valid = 1'b0;
        end
        drain();
    endtask

    task automatic test_backpressure();
        int issued;
        logic acc;
        issued = 0;
        @(posedge clk); #1;
        res_ready = 1'b0;
        r1 = rand_req();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            acc = r1.valid && p1_ready;
            checks++;
            if (p1_ready !== (k < 2)) begin
                errors++;
                $display("FAIL bp_ready%0d: got %0d, want %0d", k, p1_ready, (k < 2));
            end
            if (k >= 2) begin
                checks++;
                if (exp_q.size() == 0 || res_valid !== 1'b1 ||
                    {res_y1, res_y2, res_tag} !== {exp_q[0].y1, exp_q[0].y2, exp_q[0].tag}) begin
                    errors++;
                    $display("FAIL bp_hold%0d: got valid=%0d y1=%h tag=%h, want oldest op held",
                             k, res_valid, res_y1, res_tag);
                end
            end
            @(posedge clk); #1;
            if (acc) begin
                issued++;
                if (issued < 3) r1 = rand_req();
                else r1.valid = 1'b0;
            end
        end
        checks++;
        if (issued != 2 || exp_q.size() != 2) begin
            errors++;
            $display("FAIL bp_count: got issued=%0d outstanding=%0d, want 2 2", issued, exp_q.size());
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        @(posedge clk); #1;
        res_ready = 1'b0;
        r0 = rand_req();
        @(posedge clk); #1;
        r0.valid = 1'b0;
        r1 = rand_req();
        @(posedge clk); #1;
        r1.valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, res_valid, p0_ready, p1_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL midflight_full: got busy,valid,rdy0,rdy1=%b, want 1100",
                     {busy, res_valid, p0_ready, p1_ready});
        end
        @(posedge clk); #1;
        resetn = 1'b0;
        r0 = rand_req();
        r1 = rand_req();
        @(negedge clk);
        checks++;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midflight_ready: got %b, want 00", {p0_ready, p1_ready});
        end
        @(negedge clk);
        checks++;
        if ({res_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL midflight_flush: got valid=%0d busy=%0d, want 0 0", res_valid, busy);
        end
        @(posedge clk); #1;
        resetn    = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({p0_ready, p1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL midflight_first_grant: got %b, want 10", {p0_ready, p1_ready});
        end
        drain();
    endtask

    task automatic test_random();
        logic a0, a1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            a0 = r0.valid && p0_ready;
            a1 = r1.valid && p1_ready;
            @(posedge clk); #1;
            if (!r0.valid || a0) begin
                r0 = rand_req();
                r0.valid = 1'($urandom);
            end
            if (!r1.valid || a1) begin
                r1 = rand_req();
                r1.valid = 1'($urandom);
            end
            res_ready = ($urandom_range(3) != 0);
        end
        drain();
    endtask

    task automatic test_fixed_priority();
        exp_t fe;
        int n;
        @(posedge clk); #1;
        fres_ready = 1'b1;
        f0 = '{valid: 1'b1, form: 1'b0, vec: 2'd2, a: 32'h1, b: 32'h10, c: 32'h2, d: 32'h20, tag: 4'hA};
        f1 = rand_req();
        fe = model_of(f1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({fp_p0_ready, fp_p1_ready} !== 2'b10) begin
                errors++;
                $display("FAIL fixed_grant%0d: got %b, want 10", k, {fp_p0_ready, fp_p1_ready});
            end
            if (k >= 2) begin
                checks++;
                if ({fp_res_valid, fp_res_src, fp_res_y1, fp_res_y2, fp_res_tag} !==
                    {1'b1, 1'b0, 32'h3, 32'h30, 4'hA}) begin
                    errors++;
                    $display("FAIL fixed_result%0d: got valid=%0d src=%0d y1=%h y2=%h tag=%h, want 1 0 3 30 a",
                             k, fp_res_valid, fp_res_src, fp_res_y1, fp_res_y2, fp_res_tag);
                end
            end
            @(posedge clk); #1;
        end
        f0.valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!fp_p1_ready && n < 10);
        @(posedge clk); #1;
        f1.valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(fp_res_valid && fp_res_src) && n < 10);
        checks++;
        if ({fp_res_valid, fp_res_src, fp_res_y1, fp_res_y2, fp_res_tag} !==
            {1'b1, 1'b1, fe.y1, fe.y2, fe.tag}) begin
            errors++;
            $display("FAIL fixed_p1_late: got valid=%0d src=%0d y1=%h y2=%h tag=%h, want 1 1 %h %h %h",
                     fp_res_valid, fp_res_src, fp_res_y1, fp_res_y2, fp_res_tag, fe.y1, fe.y2, fe.tag);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (fp_busy !== 1'b0) begin
            errors++;
            $display("FAIL fixed_idle: got busy=%0d, want 0", fp_busy);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        last_port  = 1'b1;
        r0         = '0;
        r1         = '0;
        f0         = '0;
        f1         = '0;
        res_ready  = 1'b1;
        fres_ready = 1'b1;
        resetn     = 1'b0;
        test_reset();
        test_single();
        test_wide();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_random();
        test_fixed_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
